// File: rtl/bin2bcd_seg8_if.sv
// rtl/bin2bcd_seg8_if.sv - start/result bus between application logic and the BCD converter
interface bin2bcd_seg8_if #(
   parameter int BIN_W = 27
);
   logic [BIN_W-1:0] I_BIN;
   logic             I_START;
   logic             O_BUSY;
   logic             O_DONE;
   logic             O_OVF;
   logic [3:0]       O_SEG0;
   logic [3:0]       O_SEG1;
   logic [3:0]       O_SEG2;
   logic [3:0]       O_SEG3;
   logic [3:0]       O_SEG4;
   logic [3:0]       O_SEG5;
   logic [3:0]       O_SEG6;
   logic [3:0]       O_SEG7;

   // converter side
   modport slave (
      input  I_BIN, I_START,
      output O_BUSY, O_DONE, O_OVF,
      output O_SEG0, O_SEG1, O_SEG2, O_SEG3, O_SEG4, O_SEG5, O_SEG6, O_SEG7
   );

   // requester side
   modport master (
      output I_BIN, I_START,
      input  O_BUSY, O_DONE, O_OVF,
      input  O_SEG0, O_SEG1, O_SEG2, O_SEG3, O_SEG4, O_SEG5, O_SEG6, O_SEG7
   );
endinterface

// File: rtl/bin2bcd_seg8.sv
// rtl/bin2bcd_seg8.sv - sequential double-dabble binary to 8-digit BCD for the TM1638 stage
module bin2bcd_seg8 #(
   parameter int BIN_W = 27,
   parameter int N_DIG = 8
) (
   input  logic                I_CLK,
   input  logic                I_RST,
   bin2bcd_seg8_if.slave       bus
);
   localparam int BCD_W = 4 * N_DIG;

   // Largest value that fits in eight decimal digits; larger inputs saturate to it.
   localparam logic [BIN_W-1:0] MAX_VAL  = BIN_W'(99_999_999);
   // Counter value on the final (BIN_W-th) shift.
   localparam logic [4:0]       CNT_LAST = 5'(BIN_W - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SHIFT,
      ST_DONE
   } state_t;

   state_t           state_q;
   state_t           state_d;

   logic [BIN_W-1:0] shifter_q;
   logic [BCD_W-1:0] scratch_q;
   logic [BCD_W-1:0] scratch_adj;
   logic [4:0]       cnt_q;
   logic             pend_ovf_q;

   logic [BCD_W-1:0] digits_q;
   logic             ovf_q;
   logic             done_q;
   logic             busy_q;

   // State register; reset forces IDLE and thereby discards any conversion in flight.
   always_ff @(posedge I_CLK) begin
      if (I_RST) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic: accept a start only in IDLE, leave SHIFT after the last bit.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (bus.I_START) begin
               state_d = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            if (cnt_q == CNT_LAST) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Add-3 correction per nibble before each shift; nibbles never carry into each other.
   always_comb begin
      scratch_adj = scratch_q;
      for (int k = 0; k < N_DIG; k++) begin
         if (scratch_q[4*k +: 4] >= 4'd5) begin
            scratch_adj[4*k +: 4] = scratch_q[4*k +: 4] + 4'd3;
         end
      end
   end

   // Datapath and registered outputs; digits and overflow only move on the DONE edge.
   always_ff @(posedge I_CLK) begin
      if (I_RST) begin
         shifter_q  <= '0;
         scratch_q  <= '0;
         cnt_q      <= '0;
         pend_ovf_q <= 1'b0;
         digits_q   <= '0;
         ovf_q      <= 1'b0;
         done_q     <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         done_q <= 1'b0;
         busy_q <= (state_d != ST_IDLE);
         case (state_q)
            ST_IDLE: begin
               if (bus.I_START) begin
                  if (bus.I_BIN > MAX_VAL) begin
                     shifter_q  <= MAX_VAL;
                     pend_ovf_q <= 1'b1;
                  end else begin
                     shifter_q  <= bus.I_BIN;
                     pend_ovf_q <= 1'b0;
                  end
                  scratch_q <= '0;
                  cnt_q     <= '0;
               end
            end
            ST_SHIFT: begin
               // Shifter MSB enters scratch bit 0.
               {scratch_q, shifter_q} <= {scratch_adj[BCD_W-2:0], shifter_q, 1'b0};
               cnt_q                  <= cnt_q + 5'd1;
            end
            ST_DONE: begin
               digits_q <= scratch_q;
               ovf_q    <= pend_ovf_q;
               done_q   <= 1'b1;
            end
            default: begin
            end
         endcase
      end
   end

   assign bus.O_BUSY = busy_q;
   assign bus.O_DONE = done_q;
   assign bus.O_OVF  = ovf_q;
   assign bus.O_SEG0 = digits_q[3:0];
   assign bus.O_SEG1 = digits_q[7:4];
   assign bus.O_SEG2 = digits_q[11:8];
   assign bus.O_SEG3 = digits_q[15:12];
   assign bus.O_SEG4 = digits_q[19:16];
   assign bus.O_SEG5 = digits_q[23:20];
   assign bus.O_SEG6 = digits_q[27:24];
   assign bus.O_SEG7 = digits_q[31:28];
endmodule

// File: doc/bin2bcd_seg8.md
# bin2bcd_seg8

Sequential binary-to-BCD converter that produces the eight 4-bit digit buses feeding the TM1638 display driver's `seg0`..`seg7` inputs. It takes a binary value on a start strobe and runs a shift-and-add-3 (double-dabble) conversion, one bit per clock. It holds the last completed result on registered outputs, so the driver never samples a partial value. It sits between application logic (counters, measurement blocks) and the TM1638 stage, on the same clock as that stage.

## Interface
Parameters:
- `BIN_W`, 27: binary input width. 27 bits covers 99,999,999.
- `N_DIG`, 8: number of BCD digits. Only the defaults are supported and verified.

Ports:
- `I_CLK`  in  1  block clock; all state changes on its rising edge.
- `I_RST`  in  1  reset, synchronous, active-high.
- `I_BIN`  in  27  unsigned binary value; sampled only when a start is accepted.
- `I_START`  in  1  conversion request; level-sampled on each edge.
- `O_BUSY`  out  1  high while a conversion is in progress.
- `O_DONE`  out  1  one-cycle pulse; new digits are valid in that cycle.
- `O_OVF`  out  1  the last accepted `I_BIN` exceeded 99,999,999.
- `O_SEG0`..`O_SEG7`  out  4 each  BCD digits. `O_SEG0` is the least significant, `O_SEG7` the most significant.

## Operation
- States: IDLE, SHIFT, DONE. Registers: 27-bit binary shifter, 32-bit BCD scratch, 5-bit bit counter, output digit registers, flags.
- IDLE:
  - If `I_START`=1, capture `I_BIN`.
  - If the captured value is greater than 99,999,999, load 99,999,999 into the shifter and set a pending-overflow bit. Otherwise load `I_BIN` and clear the pending bit.
  - Clear the scratch and the counter, then go to SHIFT.
- SHIFT, one bit per cycle:
  - For each scratch nibble ≥5, add 3 to it; nibble adds are 4-bit and never carry between nibbles.
  - Shift {scratch, shifter} left by 1, with the shifter MSB entering scratch bit 0.
  - Increment the counter. When counter = 26 (the 27th shift), go to DONE.
- DONE:
  - Copy scratch nibble k to `O_SEGk`.
  - Copy the pending-overflow bit to `O_OVF`.
  - Set `O_DONE`=1 for the next cycle and go to IDLE.
- `O_BUSY` = registered (state ≠ IDLE).
- `I_START` is ignored in SHIFT and DONE. There is no queueing, and a dropped start is not flagged.
- `O_SEG*` and `O_OVF` change only on the DONE edge or on reset. They hold between conversions.
- Every output digit is always in 0..9. Values 10..15 never appear.

## Timing
- Start accepted at edge N, when state is IDLE and `I_START`=1.
- Shifts occur at edges N+1..N+27.
- At edge N+28: outputs are updated, `O_DONE` is set and the state becomes IDLE.
- `O_BUSY` is high in the cycles after edges N..N+27 and low after edge N+28.
- `O_DONE` is high only in the cycle after edge N+28.
- The earliest next start is accepted at edge N+29. A start held high continuously gives one conversion per 29 cycles.
- `I_START` is held high during the `O_DONE` cycle: it is accepted at N+29. `O_DONE` and `O_BUSY` are never both high.
- Reset, including mid-conversion, takes effect at the next edge with `I_RST`=1:
  - state becomes IDLE;
  - `O_BUSY`, `O_DONE` and `O_OVF` become 0;
  - all `O_SEG*` become 4'h0, and the scratch, shifter and counter are cleared;
  - the in-flight conversion is discarded and no `O_DONE` is produced.
- Reset has priority over `I_START` on the same edge.

## Test plan
- Reset → `O_SEG7`..`O_SEG0` = 0,0,0,0,0,0,0,0, with `O_BUSY`, `O_DONE` and `O_OVF` all 0. Outputs hold with `I_START`=0 for 100 cycles.
- Start with `I_BIN`=12,345,678 → `O_DONE` pulses exactly 28 edges after acceptance. Then `O_SEG7`..`O_SEG0` = 1,2,3,4,5,6,7,8 and `O_OVF`=0. `O_BUSY` is high for exactly 28 cycles.
- Boundaries:
  - `I_BIN`=0 → all digits 0.
  - `I_BIN`=99,999,999 → all digits 9, `O_OVF`=0.
  - `I_BIN`=100,000,000 → all digits 9, `O_OVF`=1.
  - `I_BIN`=134,217,727 → all digits 9, `O_OVF`=1.
  - A following conversion of 5 → digits 0,0,0,0,0,0,0,5 and `O_OVF`=0.
- Start pulses while busy, with `I_BIN` changed to 42 mid-conversion of 87,654,321 → the result is 8,7,6,5,4,3,2,1 and there is only one `O_DONE`. `I_START` held high continuously → `O_DONE` every 29 cycles.
- Reset asserted on shift edge 10 of a conversion of 11,111,111, after a prior result of 22 → digits become 0 at the reset edge, no `O_DONE` follows, and `O_BUSY`=0. A fresh start then completes normally.
- Randomized: 10,000 values in 0..2^27-1 → each result matches the reference model min(v, 99,999,999) in decimal, with `O_OVF` = (v > 99,999,999).
